// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver: oversampled rx, valid/ready byte output, framing and overrun flags
module uart_rx #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    // Last count of the half-bit wait in START and of a full bit period elsewhere
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic          r_sync1;
    logic          r_sync2;
    logic          w_rx_s;

    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_frame_err;
    logic          r_overrun;

    logic          w_cnt_done;
    logic          w_cnt_run;
    logic          w_start_ok;
    logic          w_bit_sample;
    logic          w_frame_ok;
    logic          w_frame_bad;
    logic          w_load;
    logic          w_drop;

    assign w_rx_s = r_sync2;

    // START waits half a bit so every later sample lands mid-bit
    assign w_cnt_done = (r_state == S_START) ? (r_cnt == HALF_LAST) : (r_cnt == FULL_LAST);

    // A new byte loads when the holding register is empty or is being emptied this cycle
    assign w_load = w_frame_ok && (!r_valid || i_ready);
    assign w_drop = w_frame_ok && r_valid && !i_ready;

    // Two-flop synchronizer; flops reset to the idle line level
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) w_next = S_START;
            end
            S_START: begin
                if (w_cnt_done) w_next = w_rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_cnt_done && (r_idx == 3'd7)) w_next = S_STOP;
            end
            S_STOP: begin
                if (w_cnt_done) w_next = w_rx_s ? S_IDLE : S_BREAK;
            end
            S_BREAK: begin
                if (w_rx_s) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // FSM outputs: counter enable and the sampling / frame-end strobes
    always_comb begin
        w_cnt_run    = 1'b0;
        w_start_ok   = 1'b0;
        w_bit_sample = 1'b0;
        w_frame_ok   = 1'b0;
        w_frame_bad  = 1'b0;
        case (r_state)
            S_START: begin
                w_cnt_run  = 1'b1;
                w_start_ok = w_cnt_done && !w_rx_s;
            end
            S_DATA: begin
                w_cnt_run    = 1'b1;
                w_bit_sample = w_cnt_done;
            end
            S_STOP: begin
                w_cnt_run   = 1'b1;
                w_frame_ok  = w_cnt_done && w_rx_s;
                w_frame_bad = w_cnt_done && !w_rx_s;
            end
            default: begin
                w_cnt_run = 1'b0;
            end
        endcase
    end

    // Bit-period counter, bit index and LSB-first shift register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
        end else begin
            if (w_cnt_run && !w_cnt_done) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= '0;
            end
            if (w_start_ok) begin
                r_idx <= 3'd0;
            end else if (w_bit_sample) begin
                r_idx <= r_idx + 3'd1;
            end
            if (w_bit_sample) begin
                r_shift <= {w_rx_s, r_shift[7:1]};
            end
        end
    end

    // Output holding register and one-cycle error pulses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_load) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
            r_frame_err <= w_frame_bad;
            r_overrun   <= w_drop;
        end
    end

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for the icestick 12 MHz design: oversamples the asynchronous `rx` pin, de-serialises 8N1 frames (LSB first) and presents each byte on a valid/ready output port. It sits directly downstream of the `rx` pin and upstream of `top`'s byte-processing logic. It also flags framing errors and overruns.

## Interface
- `CLKS_PER_BIT`, 104. Clocks per bit: 12 MHz / 115200 baud. Must be at least 4.
- `clk`  input  1  System clock, 12 MHz. All flops are on the rising edge.
- `rst_n`  input  1  Asynchronous, active-low reset.
- `rx`  input  1  Serial line. Asynchronous to `clk`. Idle level is high.
- `data`  output  8  Received byte. Stable while `valid` is high.
- `valid`  output  1  A byte is available on `data`.
- `ready`  input  1  Consumer accepts the byte. A transfer occurs on any cycle where `valid && ready`.
- `frame_err`  output  1  One-cycle pulse when the stop bit is sampled low.
- `overrun`  output  1  One-cycle pulse when a completed byte is dropped because the holding register is full.

## Operation
- Input synchronizer:
  - `rx` passes through a 2-FF synchronizer whose flops reset to 1.
  - All logic uses the synchronized signal `rx_s`.
- Bit counter width is `$clog2(CLKS_PER_BIT)` bits.
- Bit index is 3 bits.
- Shift register is 8 bits. Bits are shifted in LSB first.
- FSM states and transitions:
  - `IDLE`: go to `START` on `rx_s == 0`, with the counter cleared.
  - `START`: count `CLKS_PER_BIT/2 - 1` cycles, then sample `rx_s`.
    - Sample is 0: go to `DATA`, with the counter and bit index cleared.
    - Sample is 1 (glitch): return to `IDLE`. No output.
  - `DATA`: every `CLKS_PER_BIT` cycles, sample `rx_s` into bit position `idx`.
    - After `idx == 7` is sampled, go to `STOP`.
  - `STOP`: after `CLKS_PER_BIT` cycles, sample `rx_s`.
    - Sample is 1: the frame completes. Return to `IDLE`.
    - Sample is 0: pulse `frame_err`, discard the byte, and go to `BREAK`.
  - `BREAK`: wait for `rx_s == 1`, then go to `IDLE`. A held-low line produces exactly one `frame_err`.
- Output holding register, evaluated on the frame-complete cycle:
  - If `!valid`, or `valid && ready` in the same cycle: load `data` and set `valid`. In the simultaneous case the old byte transfers and the new byte replaces it with no bubble.
  - If `valid && !ready`: keep the old `data`, pulse `overrun`, and drop the new byte.
- `valid` clears on a transfer cycle unless a new byte loads in that same cycle.
- `data` changes only on a load.
- Reception never stalls for back-pressure. The FSM always returns to `IDLE` on schedule.
- Reset:
  - Asserting `rst_n` at any time, including mid-frame, forces the following immediately: FSM to `IDLE`, `data` = 0x00, `valid` = 0, `frame_err` = 0, `overrun` = 0, synchronizer flops = 1, counters = 0.
  - After release, a partial frame still on the line is treated as fresh input. Its first low bit is taken as a start bit.

## Timing
- Let t0 be the first rising edge of `clk` at which `rx` is sampled low by the first synchronizer flop.
  - `rx_s` falls at t0+2.
  - The start bit is sampled at t0+2+`CLKS_PER_BIT/2`.
  - Data bit k is sampled `CLKS_PER_BIT*(k+1)` cycles after the start-bit sample.
  - The stop bit is sampled `9*CLKS_PER_BIT` cycles after the start-bit sample.
- `valid` rises, or `frame_err`/`overrun` pulses, on the cycle after the stop-bit sample.
  - Default latency from t0 is 2+52+936+1 = 991 cycles.
- Back-to-back frames: `IDLE` is re-entered about half a bit before the nominal stop-bit end, so the next start edge is never missed.
  - Sustained rate is 1 byte per 10 bit times.
- Tolerated baud mismatch is at least ±2% at the default parameter.
- `frame_err` and `overrun` are never high in the same cycle as each other.

## Test plan
- **Nominal bytes:** send 0xFF, 0x00, 0x11, 0x01, 0x02, 0x03, 0x04 at 8680 ns/bit with `ready` held at 1.
  - Required: 7 `valid` pulses with matching `data`, no `frame_err`, no `overrun`.
- **Glitch rejection:** drive `rx` low for 2 µs, then high.
  - Required: no `valid` and no `frame_err`; FSM back in `IDLE`.
  - Then send 0xA5. Required: 0xA5 is received.
- **Framing error:** send 0x3C with a low stop bit, hold `rx` low for 3 bit times, then release.
  - Required: exactly one `frame_err` pulse, no `valid`.
  - A following 0x5A is received correctly.
- **Back-pressure and overrun:** hold `ready` at 0 and send 0x12 then 0x34.
  - Required: `valid`=1 with `data`=0x12 throughout, and one `overrun` pulse at the end of 0x34.
  - Raise `ready`. Required: 0x12 transfers once, then `valid`=0.
- **Simultaneous accept and load:** hold 0x55 pending, then assert `ready` exactly on the frame-complete cycle of 0x66.
  - Required: 0x55 transfers, `data`=0x66 with `valid` still 1, no `overrun`.
- **Reset mid-frame:** pulse `rst_n` low during bit 4 of 0x99.
  - Required: all outputs 0 immediately.
  - Then send 0xC3 after one idle bit time. Required: only 0xC3 is received.
